mem_access: RTL

Memory-access stage that sits directly downstream of the execute ALU. It takes the ALU result as an effective address (or pass-through value) plus store data and a memory opcode, and performs alignment checking, byte-lane steering and the data-bus request/ready handshake. Loads are sign- or zero-extended. It presents a registered writeback bundle to the writeback stage and stalls the pipeline while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access stage: alignment check, byte-lane steering, data-bus handshake
// and a registered writeback bundle; stalls upstream while a bus access is open.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        in_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        wen_in,
    output logic        dbus_req,
    output logic [3:0]  dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ready,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exp_adel,
    output logic        exp_ades,
    output logic [31:0] bad_vaddr,
    output logic        stall_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // What the writeback register loads this cycle.
    typedef enum logic [2:0] {
        OUT_KEEP   = 3'd0,
        OUT_BUBBLE = 3'd1,
        OUT_PASS   = 3'd2,
        OUT_EXC    = 3'd3,
        OUT_RESULT = 3'd4,
        OUT_HELD   = 3'd5
    } out_sel_t;

    function automatic logic f_is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: f_is_load = 1'b1;
            default:                             f_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: f_is_store = 1'b1;
            default:             f_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic f_aligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: f_aligned = (lo[0] == 1'b0);
            OP_LW, OP_SW:         f_aligned = (lo == 2'b00);
            default:              f_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] f_store_we(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_SB:   f_store_we = 4'b0001 << lo;
            OP_SH:   f_store_we = lo[1] ? 4'b1100 : 4'b0011;
            OP_SW:   f_store_we = 4'b1111;
            default: f_store_we = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_store_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   f_store_wdata = {4{d[7:0]}};
            OP_SH:   f_store_wdata = {2{d[15:0]}};
            OP_SW:   f_store_wdata = d;
            default: f_store_wdata = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [3:0] op, input logic [1:0] lo,
                                                   input logic [31:0] rdata);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = rdata[{lo, 3'b000} +: 8];
        v_half = rdata[{lo[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   f_load_extract = {{24{v_byte[7]}}, v_byte};
            OP_LBU:  f_load_extract = {24'd0, v_byte};
            OP_LH:   f_load_extract = {{16{v_half[15]}}, v_half};
            OP_LHU:  f_load_extract = {16'd0, v_half};
            OP_LW:   f_load_extract = rdata;
            default: f_load_extract = 32'd0;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    out_sel_t    w_out_sel;
    logic        w_launch;
    logic        w_req_done;
    logic        w_capture_hold;
    logic        w_kill_nxt;
    logic        w_is_mem;
    logic        w_aligned;
    logic        w_res_wen;
    logic [31:0] w_res_data;

    logic        r_kill;
    logic [3:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic        r_hold_wen;
    logic [31:0] r_hold_data;
    logic        r_dbus_req;
    logic [3:0]  r_dbus_we;
    logic [31:0] r_dbus_addr;
    logic [31:0] r_dbus_wdata;
    logic        r_wb_valid;
    logic        r_wb_wen;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_exp_adel;
    logic        r_exp_ades;
    logic [31:0] r_bad_vaddr;

    assign w_is_mem   = f_is_load(mem_op) | f_is_store(mem_op);
    assign w_aligned  = f_aligned(mem_op, alu_result[1:0]);
    assign w_res_wen  = f_is_load(r_op) ? r_wen : 1'b0;
    assign w_res_data = f_is_load(r_op) ? f_load_extract(r_op, r_addr_lo, dbus_rdata) : 32'd0;

    // Upstream stall: a bus access is open, or an aligned memory op is about to open one.
    assign stall_o = (r_state != IDLE) |
                     ((r_state == IDLE) & in_valid & w_is_mem & w_aligned & ~flush_i);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state, kill flag and writeback-source selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_out_sel      = OUT_KEEP;
        w_launch       = 1'b0;
        w_req_done     = 1'b0;
        w_capture_hold = 1'b0;
        w_kill_nxt     = r_kill;
        case (r_state)
            IDLE: begin
                w_kill_nxt = 1'b0;
                if (flush_i) begin
                    w_out_sel = OUT_BUBBLE;
                end else if (stall_i) begin
                    w_out_sel = OUT_KEEP;
                end else if (in_valid) begin
                    if (!w_is_mem) begin
                        w_out_sel = OUT_PASS;
                    end else if (w_aligned) begin
                        w_launch    = 1'b1;
                        w_out_sel   = OUT_BUBBLE;
                        w_state_nxt = REQ;
                    end else begin
                        w_out_sel = OUT_EXC;
                    end
                end else begin
                    w_out_sel = OUT_BUBBLE;
                end
            end
            REQ: begin
                if (dbus_ready) begin
                    w_req_done = 1'b1;
                    w_kill_nxt = 1'b0;
                    if (r_kill || flush_i) begin
                        w_out_sel   = OUT_BUBBLE;
                        w_state_nxt = IDLE;
                    end else if (stall_i) begin
                        w_capture_hold = 1'b1;
                        w_out_sel      = OUT_KEEP;
                        w_state_nxt    = HOLD;
                    end else begin
                        w_out_sel   = OUT_RESULT;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    // The bus cannot be aborted: a flush only marks the access for discard.
                    if (flush_i) begin
                        w_kill_nxt = 1'b1;
                        w_out_sel  = OUT_BUBBLE;
                    end else if (stall_i) begin
                        w_out_sel = OUT_KEEP;
                    end else begin
                        w_out_sel = OUT_BUBBLE;
                    end
                end
            end
            HOLD: begin
                if (flush_i) begin
                    w_out_sel   = OUT_BUBBLE;
                    w_state_nxt = IDLE;
                end else if (stall_i) begin
                    w_out_sel = OUT_KEEP;
                end else begin
                    w_out_sel   = OUT_HELD;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_out_sel   = OUT_BUBBLE;
                w_kill_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, bus drive, holding register and writeback output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill       <= 1'b0;
            r_op         <= 4'd0;
            r_addr_lo    <= 2'd0;
            r_rd         <= 5'd0;
            r_wen        <= 1'b0;
            r_hold_wen   <= 1'b0;
            r_hold_data  <= 32'd0;
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= 4'd0;
            r_dbus_addr  <= 32'd0;
            r_dbus_wdata <= 32'd0;
            r_wb_valid   <= 1'b0;
            r_wb_wen     <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'd0;
            r_exp_adel   <= 1'b0;
            r_exp_ades   <= 1'b0;
            r_bad_vaddr  <= 32'd0;
        end else begin
            r_kill <= w_kill_nxt;
            if (w_launch) begin
                r_op         <= mem_op;
                r_addr_lo    <= alu_result[1:0];
                r_rd         <= rd_in;
                r_wen        <= wen_in;
                r_dbus_req   <= 1'b1;
                r_dbus_we    <= f_store_we(mem_op, alu_result[1:0]);
                r_dbus_addr  <= {alu_result[31:2], 2'b00};
                r_dbus_wdata <= f_store_wdata(mem_op, store_data);
            end else if (w_req_done) begin
                r_dbus_req <= 1'b0;
            end
            if (w_capture_hold) begin
                r_hold_wen  <= w_res_wen;
                r_hold_data <= w_res_data;
            end
            case (w_out_sel)
                OUT_BUBBLE: begin
                    r_wb_valid <= 1'b0;
                    r_wb_wen   <= 1'b0;
                    r_exp_adel <= 1'b0;
                    r_exp_ades <= 1'b0;
                end
                OUT_PASS: begin
                    r_wb_valid <= 1'b1;
                    r_wb_wen   <= wen_in;
                    r_wb_rd    <= rd_in;
                    r_wb_data  <= alu_result;
                    r_exp_adel <= 1'b0;
                    r_exp_ades <= 1'b0;
                end
                OUT_EXC: begin
                    r_wb_valid  <= 1'b1;
                    r_wb_wen    <= 1'b0;
                    r_wb_rd     <= rd_in;
                    r_exp_adel  <= f_is_load(mem_op);
                    r_exp_ades  <= f_is_store(mem_op);
                    r_bad_vaddr <= alu_result;
                end
                OUT_RESULT: begin
                    r_wb_valid <= 1'b1;
                    r_wb_wen   <= w_res_wen;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= w_res_data;
                    r_exp_adel <= 1'b0;
                    r_exp_ades <= 1'b0;
                end
                OUT_HELD: begin
                    r_wb_valid <= 1'b1;
                    r_wb_wen   <= r_hold_wen;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= r_hold_data;
                    r_exp_adel <= 1'b0;
                    r_exp_ades <= 1'b0;
                end
                default: begin
                    r_wb_valid <= r_wb_valid;
                end
            endcase
        end
    end

    assign dbus_req   = r_dbus_req;
    assign dbus_we    = r_dbus_we;
    assign dbus_addr  = r_dbus_addr;
    assign dbus_wdata = r_dbus_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_wen     = r_wb_wen;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign exp_adel   = r_exp_adel;
    assign exp_ades   = r_exp_ades;
    assign bad_vaddr  = r_bad_vaddr;

endmodule
